// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  localparam int BYTE_W   = 8;
  localparam int LOCK_MAX = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Counter/pointer width that stays legal (>=1) for single-entry ranges.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_ptr, wrapping modulo NCH.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int PTRW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [PTRW-1:0] last_ptr,
  output logic [NCH-1:0]  onehot,
  output logic [PTRW-1:0] idx,
  output logic            any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Offset 1 first so the previous winner is considered last.
    for (int k = 1; k <= NCH; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!any && req[i] && (i == ((int'(last_ptr) + k) % NCH))) begin
          any       = 1'b1;
          idx       = PTRW'(i);
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-channel round-robin arbiter serialising one (ADDRW+8)-bit word per grant onto an 8-bit bus, LSB first.
// Define ARB_LOCK_EN to add the lock input (capped consecutive re-grants of a locked channel).
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int ADDRW = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            req,
  input  logic [NCH*(ADDRW+8)-1:0]  data_in,
`ifdef ARB_LOCK_EN
  input  logic [NCH-1:0]            lock,
`endif
  input  logic                      bus_ready,
  output logic [BYTE_W-1:0]         data_out,
  output logic                      valid_out,
  output logic [NCH-1:0]            grant,
  output logic                      done,
  output logic                      busy
);

  localparam int PW    = ADDRW + 8;
  localparam int BEATS = PW / BYTE_W;
  localparam int CW    = clog2_min1(BEATS);
  localparam int PTRW  = clog2_min1(NCH);

  if ((PW % BYTE_W) != 0) begin : g_pw_check
    $error("bus_arbiter_rr: ADDRW+8 must be a multiple of 8");
  end
  if ((NCH < 1) || (NCH > 8)) begin : g_nch_check
    $error("bus_arbiter_rr: NCH must be in 1..8");
  end

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PTRW-1:0]   last_ptr;
  logic [PTRW-1:0]   gidx;

  logic [PTRW-1:0]   pick_ptr;
  logic [PTRW-1:0]   pick_idx;
  logic [NCH-1:0]    pick_onehot;
  logic              pick_any;

  logic [PW-1:0]     payload;
  logic [BYTE_W-1:0] cur_byte;
  logic              last_beat;
  logic              lock_take;

  always_comb begin
    payload = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gidx == PTRW'(i)) payload = data_in[i*PW +: PW];
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == CW'(b)) cur_byte = payload[b*BYTE_W +: BYTE_W];
    end
  end

  assign valid_out = (state == ST_XFER);
  assign busy      = valid_out;
  assign data_out  = valid_out ? cur_byte : '0;
  assign last_beat = valid_out && bus_ready && (cnt == CW'(BEATS - 1));
  assign done      = last_beat;

  // At the last beat the current channel becomes the pointer, so it ranks lowest for the hand-off.
  assign pick_ptr = valid_out ? gidx : last_ptr;

  rr_pick #(
    .NCH  (NCH),
    .PTRW (PTRW)
  ) u_pick (
    .req      (req),
    .last_ptr (pick_ptr),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef ARB_LOCK_EN
  logic [2:0] lock_cnt;

  assign lock_take = lock[gidx] && req[gidx] && (lock_cnt < 3'(LOCK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (last_beat) begin
      lock_cnt <= lock_take ? (lock_cnt + 3'd1) : 3'd0;
    end
  end
`else
  assign lock_take = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      cnt      <= '0;
      last_ptr <= PTRW'(NCH - 1);
      gidx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state <= ST_XFER;
            grant <= pick_onehot;
            gidx  <= pick_idx;
            cnt   <= '0;
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            cnt <= '0;
            // A locked re-grant keeps grant, gidx and last_ptr untouched.
            if (!lock_take) begin
              last_ptr <= gidx;
              if (pick_any) begin
                grant <= pick_onehot;
                gidx  <= pick_idx;
              end else begin
                state <= ST_IDLE;
                grant <= '0;
              end
            end
          end else if (bus_ready) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
